jtag_tap_bsr: RTL and testbench

- Parametrised JTAG test access port: full 16-state TAP controller, IR_W-bit instruction register with decode, 1-bit bypass register, 32-bit IDCODE register and a BSR_LEN-cell boundary scan register (BSR).
- Sits between the board JTAG pins and the core I/O boundary.
- Replaces the fixed 2-bit IR and the externally sequenced shift/update strobes with an on-chip TMS-driven controller.

---
 rtl/jtag_tap_bsr.sv | 226 ++++++++++++++++++++++
 tb/tb_jtag_tap_bsr.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_bsr.sv
// jtag_tap_bsr: IEEE 1149.1-style test access port.
// The TAP controller is driven by TMS. It holds an IR_W-bit instruction register,
// a bypass bit, a 32-bit IDCODE register and a BSR_LEN-cell boundary scan
// register. The BSR sits between the core I/O (sys_in) and the pins (sys_out).
module jtag_tap_bsr #(
    parameter int unsigned IR_W       = 4,
    parameter int unsigned BSR_LEN    = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0765,
    parameter int unsigned OP_EXTEST  = 0,
    parameter int unsigned OP_SAMPLE  = 1,
    parameter int unsigned OP_IDCODE  = 2
) (
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TMS,
    input  logic               TDI,
    output logic               TDO,
    output logic               TDO_en,
    input  logic [BSR_LEN-1:0] sys_in,
    output logic [BSR_LEN-1:0] sys_out,
    output logic [IR_W-1:0]    inst,
    output logic [3:0]         tap_state
);

    // Opcodes resized to the instruction width so that every compare matches in width.
    localparam logic [IR_W-1:0] INST_EXTEST = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] INST_SAMPLE = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] INST_IDCODE = IR_W'(OP_IDCODE);
    // Capture-IR pattern: the two LSBs are 01 and all other bits are 0.
    localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(2'b01);

    typedef enum logic [3:0] {
        TLR    = 4'd0,
        RTI    = 4'd1,
        SEL_DR = 4'd2,
        CAP_DR = 4'd3,
        SH_DR  = 4'd4,
        EX1_DR = 4'd5,
        PAU_DR = 4'd6,
        EX2_DR = 4'd7,
        UPD_DR = 4'd8,
        SEL_IR = 4'd9,
        CAP_IR = 4'd10,
        SH_IR  = 4'd11,
        EX1_IR = 4'd12,
        PAU_IR = 4'd13,
        EX2_IR = 4'd14,
        UPD_IR = 4'd15
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_BSR
    } dr_sel_t;

    tap_state_t         state, state_n;
    dr_sel_t            dr_sel;

    logic [IR_W-1:0]    ir_sr, ir_sr_n;
    logic [IR_W-1:0]    inst_n;
    logic               bypass, bypass_n;
    logic [31:0]        idcode_sr, idcode_sr_n;
    logic [BSR_LEN-1:0] bsr_cap, bsr_cap_n;
    logic [BSR_LEN-1:0] bsr_upd, bsr_upd_n;
    logic               tdo_n, tdo_en_n;

    assign tap_state = state;

    // Next state of the TAP controller, which TMS drives.
    always_comb begin
        // NOTE: give every combinational output a default first so that no path leaves it unassigned (no latch).
        state_n = state;
        unique case (state)
            TLR:    state_n = TMS ? TLR    : RTI;
            RTI:    state_n = TMS ? SEL_DR : RTI;
            SEL_DR: state_n = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_n = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_n = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_n = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_n = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_n = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_n = TMS ? SEL_DR : RTI;
            SEL_IR: state_n = TMS ? TLR    : CAP_IR;
            CAP_IR: state_n = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_n = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_n = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_n = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_n = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_n = TMS ? SEL_DR : RTI;
            default: state_n = TLR;
        endcase
    end

    // Decode the instruction into a data register select. Unknown opcodes select bypass.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (inst == INST_EXTEST || inst == INST_SAMPLE) begin
            dr_sel = DR_BSR;
        end else if (inst == INST_IDCODE) begin
            dr_sel = DR_IDCODE;
        end
    end

    // Instruction register: capture, shift and update.
    always_comb begin
        ir_sr_n = ir_sr;
        inst_n  = inst;
        if (state == CAP_IR) begin
            ir_sr_n = IR_CAPTURE;
        end else if (state == SH_IR) begin
            ir_sr_n           = ir_sr >> 1;
            ir_sr_n[IR_W-1]   = TDI;
        end
        if (state == UPD_IR) begin
            inst_n = ir_sr;
        end
        // Any entry into Test-Logic-Reset restores IDCODE as the current instruction.
        if (state_n == TLR) begin
            inst_n = INST_IDCODE;
        end
    end

    // Data registers: capture, shift and update of the register that is selected.
    always_comb begin
        bypass_n    = bypass;
        idcode_sr_n = idcode_sr;
        bsr_cap_n   = bsr_cap;
        bsr_upd_n   = bsr_upd;
        unique case (state)
            CAP_DR: begin
                unique case (dr_sel)
                    DR_BYPASS: bypass_n    = 1'b0;
                    DR_IDCODE: idcode_sr_n = IDCODE_VAL;
                    DR_BSR:    bsr_cap_n   = sys_in;
                    default:   bypass_n    = 1'b0;
                endcase
            end
            SH_DR: begin
                unique case (dr_sel)
                    DR_BYPASS: bypass_n    = TDI;
                    DR_IDCODE: idcode_sr_n = {TDI, idcode_sr[31:1]};
                    DR_BSR: begin
                        // Written as a shift plus an MSB write so that it also works when BSR_LEN is 1.
                        bsr_cap_n              = bsr_cap >> 1;
                        bsr_cap_n[BSR_LEN-1]   = TDI;
                    end
                    default:   bypass_n    = TDI;
                endcase
            end
            UPD_DR: begin
                if (dr_sel == DR_BSR) begin
                    bsr_upd_n = bsr_cap;
                end
            end
            default: ;
        endcase
    end

    // TDO is registered. It presents the LSB of the register that shifts in the state being entered.
    always_comb begin
        tdo_n    = 1'b0;
        tdo_en_n = 1'b0;
        if (state_n == SH_IR) begin
            tdo_n    = ir_sr_n[0];
            tdo_en_n = 1'b1;
        end else if (state_n == SH_DR) begin
            tdo_en_n = 1'b1;
            unique case (dr_sel)
                DR_BYPASS: tdo_n = bypass_n;
                DR_IDCODE: tdo_n = idcode_sr_n[0];
                DR_BSR:    tdo_n = bsr_cap_n[0];
                default:   tdo_n = bypass_n;
            endcase
        end
    end

    // TAP controller state register.
    always_ff @(posedge TCK or posedge TRST) begin
        // NOTE: sequential state always takes non-blocking assignments, so every register samples pre-edge values.
        if (TRST) begin
            state <= TLR;
        end else begin
            state <= state_n;
        end
    end

    // Instruction and data registers.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_sr     <= '0;
            inst      <= INST_IDCODE;
            bypass    <= 1'b0;
            idcode_sr <= '0;
            bsr_cap   <= '0;
            bsr_upd   <= '0;
        end else begin
            ir_sr     <= ir_sr_n;
            inst      <= inst_n;
            bypass    <= bypass_n;
            idcode_sr <= idcode_sr_n;
            bsr_cap   <= bsr_cap_n;
            bsr_upd   <= bsr_upd_n;
        end
    end

    // Registered serial output and output enable.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else begin
            TDO    <= tdo_n;
            TDO_en <= tdo_en_n;
        end
    end

    // Pin mux: the BSR drives the pins only under EXTEST. Otherwise the core values pass through.
    always_comb begin
        sys_out = sys_in;
        if (inst == INST_EXTEST) begin
            sys_out = bsr_upd;
        end
    end

endmodule

// File: tb/tb_jtag_tap_bsr.sv
// tb_jtag_tap_bsr: directed self-checking bench for jtag_tap_bsr with default parameters.
module tb_jtag_tap_bsr;

    logic       TCK;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic       TDO_en;
    logic [7:0] sys_in;
    logic [7:0] sys_out;
    logic [3:0] inst;
    logic [3:0] tap_state;

    int n_cmp;
    int n_fail;

    jtag_tap_bsr dut (
        .TCK       (TCK),
        .TRST      (TRST),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .TDO_en    (TDO_en),
        .sys_in    (sys_in),
        .sys_out   (sys_out),
        .inst      (inst),
        .tap_state (tap_state)
    );

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    // One TCK cycle. Sample TDO and TDO_en for the current state, apply TMS/TDI,
    // then settle 1 time unit past the rising edge.
    task automatic step(input logic tms, input logic tdi, output logic tdo_s, output logic en_s);
        tdo_s = TDO;
        en_s  = TDO_en;
        TMS   = tms;
        TDI   = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic step_tms(input logic tms);
        logic d, e;
        step(tms, 1'b0, d, e);
    endtask

    // Shift n bits, starting from Shift-xR. TMS goes high on the last bit, which leaves the TAP in Exit1-xR.
    task automatic shift(input int n, input logic [63:0] din, output logic [63:0] dout, output logic all_en);
        logic d, e;
        dout   = '0;
        all_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            step((i == n - 1), din[i], d, e);
            dout[i] = d;
            all_en  = all_en & e;
        end
    endtask

    // Go from Run-Test/Idle to Shift-DR.
    task automatic rti_to_shdr();
        step_tms(1'b1);
        step_tms(1'b0);
        step_tms(1'b0);
    endtask

    // Load an instruction, starting from RTI. The task ends in Update-IR, before the update edge.
    task automatic load_ir(input logic [3:0] val, output logic [3:0] cap);
        logic [63:0] dout;
        logic        en;
        step_tms(1'b1);
        step_tms(1'b1);
        step_tms(1'b0);
        step_tms(1'b0);
        shift(4, {60'd0, val}, dout, en);
        cap = dout[3:0];
        step_tms(1'b1);
    endtask

    task automatic pulse_trst();
        TRST = 1'b1;
        #3;
        TRST = 1'b0;
        @(posedge TCK);
        #1;
    endtask

    task automatic test_reset();
        sys_in = 8'h3C;
        TMS    = 1'b1;
        TDI    = 1'b0;
        TRST   = 1'b1;
        #3;
        n_cmp++;
        if (tap_state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", tap_state); end
        n_cmp++;
        if (inst !== 4'd2) begin n_fail++; $display("FAIL reset_inst: got %h expected 2", inst); end
        n_cmp++;
        if (TDO !== 1'b0 || TDO_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got tdo=%b en=%b expected 0 0", TDO, TDO_en); end
        n_cmp++;
        if (sys_out !== 8'h3C) begin n_fail++; $display("FAIL reset_sys_out: got %h expected 3c", sys_out); end
        TRST = 1'b0;
        @(posedge TCK);
        #1;
        n_cmp++;
        if (tap_state !== 4'd0) begin n_fail++; $display("FAIL reset_hold_tlr: got %0d expected 0", tap_state); end
    endtask

    task automatic test_idcode();
        logic [63:0] dout;
        logic        en;
        step_tms(1'b0);
        rti_to_shdr();
        n_cmp++;
        if (tap_state !== 4'd4) begin n_fail++; $display("FAIL id_shdr_state: got %0d expected 4", tap_state); end
        shift(32, 64'd0, dout, en);
        n_cmp++;
        if (dout[31:0] !== 32'h1000_0765) begin n_fail++; $display("FAIL id_value: got %h expected 10000765", dout[31:0]); end
        n_cmp++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL id_tdo_en: got %b expected 1", en); end
        step_tms(1'b1);
        step_tms(1'b0);
        n_cmp++;
        if (tap_state !== 4'd1 || TDO_en !== 1'b0) begin n_fail++; $display("FAIL id_exit: got state=%0d en=%b expected 1 0", tap_state, TDO_en); end
    endtask

    task automatic test_bypass();
        logic [3:0]  cap;
        logic [63:0] dout;
        logic        en;
        load_ir(4'hF, cap);
        n_cmp++;
        if (cap !== 4'b0001) begin n_fail++; $display("FAIL ir_capture: got %b expected 0001", cap); end
        step_tms(1'b0);
        n_cmp++;
        if (inst !== 4'hF) begin n_fail++; $display("FAIL bypass_inst: got %h expected f", inst); end
        rti_to_shdr();
        shift(4, 64'b1101, dout, en);
        n_cmp++;
        if (dout[3:0] !== 4'b1010) begin n_fail++; $display("FAIL bypass_delay: got %b expected 1010", dout[3:0]); end
        step_tms(1'b1);
        step_tms(1'b0);
    endtask

    task automatic test_extest();
        logic [3:0]  cap;
        logic [63:0] dout;
        logic        en;
        sys_in = 8'h3C;
        load_ir(4'h1, cap);
        step_tms(1'b0);
        rti_to_shdr();
        shift(8, 64'hA5, dout, en);
        n_cmp++;
        if (dout[7:0] !== 8'h3C) begin n_fail++; $display("FAIL sample_capture: got %h expected 3c", dout[7:0]); end
        step_tms(1'b1);
        step_tms(1'b0);
        n_cmp++;
        if (sys_out !== 8'h3C) begin n_fail++; $display("FAIL preload_passthru: got %h expected 3c", sys_out); end
        load_ir(4'h0, cap);
        n_cmp++;
        if (sys_out !== 8'h3C) begin n_fail++; $display("FAIL extest_at_updir: got %h expected 3c", sys_out); end
        step_tms(1'b0);
        n_cmp++;
        if (sys_out !== 8'hA5) begin n_fail++; $display("FAIL extest_drive: got %h expected a5", sys_out); end
        sys_in = 8'h11;
        #1;
        n_cmp++;
        if (sys_out !== 8'hA5) begin n_fail++; $display("FAIL extest_hold: got %h expected a5", sys_out); end
    endtask

    task automatic test_capture();
        logic [3:0]  cap;
        logic [63:0] dout;
        logic        en;
        sys_in = 8'h96;
        load_ir(4'h1, cap);
        step_tms(1'b0);
        n_cmp++;
        if (sys_out !== 8'h96) begin n_fail++; $display("FAIL sample_passthru: got %h expected 96", sys_out); end
        rti_to_shdr();
        shift(8, 64'd0, dout, en);
        n_cmp++;
        if (dout[7:0] !== 8'h96) begin n_fail++; $display("FAIL capture_bits: got %h expected 96", dout[7:0]); end
        n_cmp++;
        if (en !== 1'b1) begin n_fail++; $display("FAIL capture_en: got %b expected 1", en); end
        step_tms(1'b1);
        step_tms(1'b0);
    endtask

    task automatic test_pause();
        logic [3:0]  cap;
        logic [63:0] d1, d2;
        logic        e1, e2;
        load_ir(4'h2, cap);
        step_tms(1'b0);
        rti_to_shdr();
        shift(10, 64'd0, d1, e1);
        step_tms(1'b0);
        for (int i = 0; i < 4; i++) step_tms(1'b0);
        n_cmp++;
        if (tap_state !== 4'd6 || TDO_en !== 1'b0) begin n_fail++; $display("FAIL pause_state: got state=%0d en=%b expected 6 0", tap_state, TDO_en); end
        step_tms(1'b1);
        step_tms(1'b0);
        shift(22, 64'd0, d2, e2);
        n_cmp++;
        if ({d2[21:0], d1[9:0]} !== 32'h1000_0765) begin n_fail++; $display("FAIL pause_rebuild: got %h expected 10000765", {d2[21:0], d1[9:0]}); end
        n_cmp++;
        if ((e1 & e2) !== 1'b1) begin n_fail++; $display("FAIL pause_en: got %b expected 1", e1 & e2); end
        step_tms(1'b1);
        step_tms(1'b0);
    endtask

    task automatic test_tlr_from_pauir();
        logic [3:0] cap;
        load_ir(4'hF, cap);
        step_tms(1'b0);
        step_tms(1'b1);
        step_tms(1'b1);
        step_tms(1'b0);
        step_tms(1'b1);
        step_tms(1'b0);
        n_cmp++;
        if (tap_state !== 4'd13) begin n_fail++; $display("FAIL reach_pauir: got %0d expected 13", tap_state); end
        for (int i = 0; i < 5; i++) step_tms(1'b1);
        n_cmp++;
        if (tap_state !== 4'd0) begin n_fail++; $display("FAIL tms_reset_state: got %0d expected 0", tap_state); end
        n_cmp++;
        if (inst !== 4'd2) begin n_fail++; $display("FAIL tms_reset_inst: got %h expected 2", inst); end
    endtask

    task automatic test_trst_mid_shift();
        logic [3:0]  cap;
        logic [63:0] dout;
        logic        en;
        step_tms(1'b0);
        sys_in = 8'h3C;
        load_ir(4'h1, cap);
        step_tms(1'b0);
        rti_to_shdr();
        shift(8, 64'h5A, dout, en);
        step_tms(1'b1);
        step_tms(1'b0);
        load_ir(4'h0, cap);
        step_tms(1'b0);
        n_cmp++;
        if (sys_out !== 8'h5A) begin n_fail++; $display("FAIL extest_preload2: got %h expected 5a", sys_out); end
        rti_to_shdr();
        step_tms(1'b0);
        step_tms(1'b0);
        n_cmp++;
        if (TDO_en !== 1'b1 || tap_state !== 4'd4) begin n_fail++; $display("FAIL mid_shift: got state=%0d en=%b expected 4 1", tap_state, TDO_en); end
        TRST = 1'b1;
        #1;
        n_cmp++;
        if (sys_out !== 8'h3C) begin n_fail++; $display("FAIL trst_sys_out: got %h expected 3c", sys_out); end
        n_cmp++;
        if (TDO_en !== 1'b0 || TDO !== 1'b0) begin n_fail++; $display("FAIL trst_tdo: got tdo=%b en=%b expected 0 0", TDO, TDO_en); end
        n_cmp++;
        if (tap_state !== 4'd0 || inst !== 4'd2) begin n_fail++; $display("FAIL trst_state: got state=%0d inst=%h expected 0 2", tap_state, inst); end
        #2;
        TRST = 1'b0;
        @(posedge TCK);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        TRST   = 1'b1;
        TMS    = 1'b1;
        TDI    = 1'b0;
        sys_in = 8'h3C;
        #2;
        test_reset();
        test_idcode();
        test_bypass();
        test_extest();
        test_capture();
        test_pause();
        test_tlr_from_pauir();
        test_trst_mid_shift();
        pulse_trst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
